fft_256_peak_detect: RTL and testbench

FFT_256_PEAK_DETECT -- requirements
Module: fft_256_peak_detect

---
 rtl/fft_256_peak_detect.sv | 119 +++++++++++
 tb/tb_fft_256_peak_detect.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fft_256_peak_detect.sv
// rtl/fft_256_peak_detect.sv - peak bin, above-threshold count and frame checks over one 256-bin FFT frame
module fft_256_peak_detect #(
  parameter logic [16:0] THRESH  = 17'd1000,
  parameter bit          SKIP_DC = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] in_real,
  input  logic signed [15:0] in_imag,
  input  logic [7:0]         in_addr,
  input  logic               in_valid,
  input  logic               abort,
  output logic [7:0]         peak_bin,
  output logic [16:0]        peak_mag,
  output logic [8:0]         above_cnt,
  output logic               frame_err,
  output logic               overrun,
  output logic               result_valid,
  output logic               busy
);
  typedef enum logic [1:0] {COLLECT, DRAIN, REPORT} state_t;
  localparam logic [7:0] BIN_INIT = SKIP_DC ? 8'd1 : 8'd0;

  state_t       state;
  logic [255:0] seen;
  logic [8:0]   distinct;
  logic         err_flag, ovr_flag;
  logic         s1_valid, s1_last, s2_valid, s2_last, s3_last;
  logic [16:0]  s1_a, s1_b, s2_mag;
  logic [7:0]   s1_addr, s2_addr;
  logic [16:0]  best_mag;
  logic [7:0]   best_bin;
  logic [8:0]   cnt;

  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    logic [16:0] e;
    e = {v[15], v};
    return v[15] ? (~e + 17'd1) : e;
  endfunction

  logic        accept, is_dup, is_last, better, skip;
  logic [16:0] mx, mn, mag;

  always_comb begin
    accept  = (state == COLLECT) && in_valid && !abort;
    is_dup  = seen[in_addr];
    is_last = !is_dup && (distinct == 9'd255);
    mx      = (s1_a >= s1_b) ? s1_a : s1_b;
    mn      = (s1_a >= s1_b) ? s1_b : s1_a;
    mag     = mx + (mn >> 1);
    skip    = SKIP_DC && (s2_addr == 8'd0);
    better  = (s2_mag > best_mag) || ((s2_mag == best_mag) && (s2_addr < best_bin));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      seen <= '0; distinct <= '0; err_flag <= 1'b0; ovr_flag <= 1'b0;
      s1_valid <= 1'b0; s1_last <= 1'b0; s2_valid <= 1'b0; s2_last <= 1'b0; s3_last <= 1'b0;
      s1_a <= '0; s1_b <= '0; s1_addr <= '0; s2_mag <= '0; s2_addr <= '0;
      best_mag <= '0; best_bin <= BIN_INIT; cnt <= '0;
      peak_bin <= '0; peak_mag <= '0; above_cnt <= '0;
      frame_err <= 1'b0; overrun <= 1'b0; result_valid <= 1'b0; busy <= 1'b0;
    end else if (abort) begin
      // Result outputs keep the last reported frame.
      state <= COLLECT;
      seen <= '0; distinct <= '0; err_flag <= 1'b0; ovr_flag <= 1'b0;
      s1_valid <= 1'b0; s1_last <= 1'b0; s2_valid <= 1'b0; s2_last <= 1'b0; s3_last <= 1'b0;
      best_mag <= '0; best_bin <= BIN_INIT; cnt <= '0;
      result_valid <= 1'b0; busy <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      // Duplicates are flagged at the input so back-to-back repeats are caught.
      s1_valid <= accept && !is_dup;
      s1_last  <= accept && is_last;
      if (accept) begin
        s1_a <= abs17(in_real);
        s1_b <= abs17(in_imag);
        s1_addr <= in_addr;
        seen[in_addr] <= 1'b1;
        if (is_dup) err_flag <= 1'b1;
        else        distinct <= distinct + 9'd1;
      end
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_mag   <= mag;
      s2_addr  <= s1_addr;
      s3_last  <= s2_last;
      if (s2_valid) begin
        if (!skip && better) begin
          best_mag <= s2_mag;
          best_bin <= s2_addr;
        end
        if (s2_mag > THRESH) cnt <= cnt + 9'd1;
      end
      case (state)
        COLLECT: begin
          busy <= accept || (distinct != 9'd0);
          if (accept && is_last) state <= DRAIN;
        end
        DRAIN: begin
          if (in_valid) ovr_flag <= 1'b1;
          if (s3_last) state <= REPORT;
        end
        default: begin
          peak_bin <= best_bin;
          peak_mag <= best_mag;
          above_cnt <= cnt;
          frame_err <= err_flag;
          overrun <= ovr_flag || in_valid;
          result_valid <= 1'b1;
          seen <= '0; distinct <= '0; err_flag <= 1'b0; ovr_flag <= 1'b0;
          best_mag <= '0; best_bin <= BIN_INIT; cnt <= '0;
          state <= COLLECT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_256_peak_detect.sv
// tb/tb_fft_256_peak_detect.sv - scoreboard bench with a bin-array reference model
module tb_fft_256_peak_detect;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, abort = 1'b0;
  logic signed [15:0] in_real = '0, in_imag = '0;
  logic [7:0] in_addr = '0;
  logic [7:0] peak_bin; logic [16:0] peak_mag; logic [8:0] above_cnt;
  logic frame_err, overrun, result_valid, busy;

  fft_256_peak_detect dut (
    .clk(clk), .rst(rst), .in_real(in_real), .in_imag(in_imag), .in_addr(in_addr),
    .in_valid(in_valid), .abort(abort), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .above_cnt(above_cnt), .frame_err(frame_err), .overrun(overrun),
    .result_valid(result_valid), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int bin; int mag; int cnt; int err; int ovr; int cyc; } exp_t;
  exp_t sb[$];
  int fa[$], fr[$], fi[$];
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int magnitude(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    return (a > b) ? a + b / 2 : b + a / 2;
  endfunction

  // Reference: first occurrence of each bin counts; peak is highest magnitude, lowest bin on ties, bin 0 excluded.
  function automatic exp_t model(input bit ovr);
    exp_t e;
    int m[256];
    bit seen[256];
    e.err = 0; e.cnt = 0; e.ovr = ovr; e.cyc = 0;
    for (int k = 0; k < 256; k++) begin m[k] = 0; seen[k] = 1'b0; end
    for (int i = 0; i < fa.size(); i++) begin
      if (seen[fa[i]]) e.err = 1;
      else begin seen[fa[i]] = 1'b1; m[fa[i]] = magnitude(fr[i], fi[i]); end
    end
    e.bin = 1; e.mag = 0;
    for (int k = 0; k < 256; k++) begin
      if (m[k] > 1000) e.cnt++;
      if (k != 0 && m[k] > e.mag) begin e.bin = k; e.mag = m[k]; end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (sb.size() == 0) chk("spurious_result_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency_cycle", cyc, e.cyc);
        chk("peak_bin", int'(peak_bin), e.bin);
        chk("peak_mag", int'(peak_mag), e.mag);
        chk("above_cnt", int'(above_cnt), e.cnt);
        chk("frame_err", int'(frame_err), e.err);
        chk("overrun", int'(overrun), e.ovr);
      end
    end
  end

  task automatic clear_frame();
    fa.delete(); fr.delete(); fi.delete();
  endtask

  task automatic add(input int a, input int re, input int im);
    fa.push_back(a); fr.push_back(re); fi.push_back(im);
  endtask

  task automatic drive_frame(input bit extra, input bit gaps);
    exp_t e;
    e = model(extra);
    for (int i = 0; i < fa.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1; in_valid = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_addr = 8'(fa[i]); in_real = 16'(fr[i]); in_imag = 16'(fi[i]);
      if (i == 1) chk("busy_mid_frame", int'(busy), 1);
    end
    e.cyc = cyc + 5;
    sb.push_back(e);
    @(posedge clk); #1;
    if (extra) begin
      in_valid = 1'b1; in_addr = 8'd3; in_real = 16'sd20000; in_imag = 16'sd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin chk("result_timeout", 0, 1); sb.delete(); end
    @(posedge clk); #1;
    chk("busy_after_result", int'(busy), 0);
  endtask

  task automatic shuffled_frame(input bit dup);
    int p[256];
    int t, j;
    clear_frame();
    for (int k = 0; k < 256; k++) p[k] = k;
    for (int k = 255; k > 0; k--) begin
      j = $urandom_range(0, k); t = p[k]; p[k] = p[j]; p[j] = t;
    end
    for (int k = 0; k < 256; k++) begin
      add(p[k], int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 4000)) - 2000);
      if (dup && k == 100) add(p[$urandom_range(0, 100)], int'($urandom_range(0, 30000)), 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_peak_bin", int'(peak_bin), 0);
    chk("rst_peak_mag", int'(peak_mag), 0);
    chk("rst_above_cnt", int'(above_cnt), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    clear_frame();
    for (int k = 0; k < 256; k++) add(k, (k == 37) ? -32768 : (100 * k) % 32768, 0);
    drive_frame(1'b0, 1'b0);

    clear_frame();
    for (int k = 0; k < 256; k++) add(k, (k == 0) ? 30000 : (k == 5) ? 8000 : 0, (k == 5) ? 8000 : 0);
    drive_frame(1'b0, 1'b0);

    clear_frame();
    for (int k = 255; k >= 0; k--) add(k, (k == 9 || k == 200) ? 5000 : 0, 0);
    drive_frame(1'b0, 1'b1);

    clear_frame();
    for (int k = 0; k < 256; k++) begin
      add(k, (k == 17) ? 5000 : 10 * k, 0);
      if (k == 17) add(17, 5000, 0);
    end
    drive_frame(1'b0, 1'b0);

    clear_frame();
    for (int k = 0; k < 256; k++) add(k, 50 * k, -7 * k);
    drive_frame(1'b1, 1'b0);
    clear_frame();
    for (int k = 0; k < 256; k++) add(k, (k == 3) ? 0 : 2000, 0);
    drive_frame(1'b0, 1'b0);

    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_addr = 8'(i); in_real = 16'sd30000; in_imag = 16'sd0;
    end
    @(posedge clk); #1;
    abort = 1'b1; in_addr = 8'd200;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("busy_after_abort", int'(busy), 0);
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < 256; k++) add(k, 0, 0);
    clear_frame();
    for (int k = 0; k < 256; k++) add(255 - k, 3 * k, 11 * k);
    drive_frame(1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      shuffled_frame(r[0]);
      drive_frame(1'b0, 1'b1);
    end

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
